// File: rtl/ae_pkg.sv
// Shared constants for the autoencoder feature path: stream geometry and the
// sequencer state encoding.
package ae_pkg;

    localparam int DATA_W   = 16;
    localparam int N_INPUTS = 18;
    localparam int SEL_W    = 5;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/mod_n_counter.sv
// Modulo-N up-counter with synchronous clear; wrap flags the terminal count N-1.
module mod_n_counter #(
    parameter int N = 18,
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap
);

    assign wrap = (count == W'(N - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/mux_sel_streamer.sv
// Walks the feature mux select 0..N_INPUTS-1 and streams each registered mux
// value over valid/ready, pulsing done once the last element is accepted.
module mux_sel_streamer #(
    parameter int N_INPUTS = ae_pkg::N_INPUTS,
    parameter int DATA_W   = ae_pkg::DATA_W,
    parameter int SEL_W    = ae_pkg::SEL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [SEL_W-1:0]  sel,
    input  logic [DATA_W-1:0] mux_data,
    output logic [DATA_W-1:0] out_data,
    output logic [SEL_W-1:0]  out_index,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    import ae_pkg::*;

    logic [1:0]       state;
    logic [SEL_W-1:0] idx;
    logic             idx_wrap;
    logic             load;

    // A new element is captured only when the output register is empty or
    // being drained this cycle, so the stream never drops or repeats data.
    assign load = (state == ST_RUN) && (!out_valid || out_ready);
    assign sel  = idx;
    assign busy = (state == ST_RUN) || (state == ST_DRAIN);

    mod_n_counter #(
        .N (N_INPUTS),
        .W (SEL_W)
    ) u_idx (
        .clk   (clk),
        .rst   (rst),
        .clear (abort),
        .en    (load && !abort),
        .count (idx),
        .wrap  (idx_wrap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            out_data  <= '0;
            out_index <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                // out_data/out_index deliberately keep their last value
                state     <= ST_IDLE;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) state <= ST_RUN;
                    end
                    ST_RUN: begin
                        if (load) begin
                            out_data  <= mux_data;
                            out_index <= idx;
                            out_valid <= 1'b1;
                            out_last  <= idx_wrap;
                            if (idx_wrap) state <= ST_DRAIN;
                        end
                    end
                    ST_DRAIN: begin
                        if (out_valid && out_ready) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            done      <= 1'b1;
                            state     <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
